// File: rtl/mem_cycle_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_cycle_seq_if
// Brief    : Request handshake and external bus pins of the machine-cycle
//            sequencer. wait_abort exists only with MEM_CYCLE_WAIT_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
interface mem_cycle_seq_if #(
  parameter int ADDR_WIDTH = 16
);
  // control-unit request side
  logic                  req_valid;
  logic [1:0]            req_type;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            req_dout;
  logic [7:0]            i_reg;
  logic                  req_ready;
  logic                  cycle_done;
  logic                  din_we;
  // pin side
  logic                  n_wait;
  logic                  n_busreq;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [7:0]            bus_dout;
  logic                  bus_oe;
  logic                  n_m1;
  logic                  n_mreq;
  logic                  n_rd;
  logic                  n_wr;
  logic                  n_rfsh;
  logic                  n_busack;
`ifdef MEM_CYCLE_WAIT_TIMEOUT_EN
  logic                  wait_abort;
`endif

  modport slave (
    input  req_valid, req_type, req_addr, req_dout, i_reg, n_wait, n_busreq,
    output req_ready, cycle_done, din_we, bus_addr, bus_dout, bus_oe,
           n_m1, n_mreq, n_rd, n_wr, n_rfsh, n_busack
`ifdef MEM_CYCLE_WAIT_TIMEOUT_EN
    , output wait_abort
`endif
  );

  modport master (
    output req_valid, req_type, req_addr, req_dout, i_reg, n_wait, n_busreq,
    input  req_ready, cycle_done, din_we, bus_addr, bus_dout, bus_oe,
           n_m1, n_mreq, n_rd, n_wr, n_rfsh, n_busack
`ifdef MEM_CYCLE_WAIT_TIMEOUT_EN
    , input wait_abort
`endif
  );
endinterface
`default_nettype wire

// File: rtl/mem_cycle_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_cycle_seq
// Brief    : Z80-style M1 / memory-read / memory-write T-state sequencer with
//            wait states, refresh phase and BUSREQ/BUSACK arbitration.
//            Optional wait-state timeout: define MEM_CYCLE_WAIT_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module mem_cycle_seq #(
  parameter int ADDR_WIDTH = 16
`ifdef MEM_CYCLE_WAIT_TIMEOUT_EN
  ,
  parameter int WAIT_TIMEOUT = 255
`endif
) (
  input  logic           clk,
  input  logic           n_reset,
  mem_cycle_seq_if.slave mem
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_t1     = 3'd1;
  localparam logic [2:0] c_st_t2     = 3'd2;
  localparam logic [2:0] c_st_tw     = 3'd3;
  localparam logic [2:0] c_st_t3     = 3'd4;
  localparam logic [2:0] c_st_t4     = 3'd5;
  localparam logic [2:0] c_st_busack = 3'd6;

  localparam logic [1:0] c_type_fetch = 2'b00;
  localparam logic [1:0] c_type_write = 2'b10;

  logic [2:0]            r_state;
  logic [2:0]            w_next_state;
  logic [1:0]            r_type;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_dout;
  logic [7:0]            r_rfsh;

  logic                  w_is_fetch;
  logic                  w_is_write;
  logic                  w_final;
  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_timeout;
  logic [2:0]            w_after_final;
  logic [15:0]           w_rfsh_full;
  logic [ADDR_WIDTH-1:0] w_rfsh_addr;

  // Reserved type 11 decodes as neither fetch nor write, i.e. a plain read.
  assign w_is_fetch  = (r_type == c_type_fetch);
  assign w_is_write  = (r_type == c_type_write);
  assign w_final     = ((r_state == c_st_t3) && !w_is_fetch) || (r_state == c_st_t4);
  assign w_req_ready = mem.n_busreq && ((r_state == c_st_idle) || w_final);
  assign w_accept    = mem.req_valid && w_req_ready;

  assign w_rfsh_full = {mem.i_reg, r_rfsh};

  generate
    if (ADDR_WIDTH >= 16) begin : g_rfsh_wide
      assign w_rfsh_addr = ADDR_WIDTH'(w_rfsh_full);
    end else begin : g_rfsh_narrow
      assign w_rfsh_addr = w_rfsh_full[ADDR_WIDTH-1:0];
    end
  endgenerate

`ifdef MEM_CYCLE_WAIT_TIMEOUT_EN
  localparam logic [7:0] c_wait_limit = 8'(WAIT_TIMEOUT);

  logic [7:0] r_wait_cnt;
  logic       r_wait_abort;

  // r_wait_cnt holds the number of TW states already spent in this cycle.
  assign w_timeout = ((r_state == c_st_t2) || (r_state == c_st_tw)) &&
                     !mem.n_wait && (r_wait_cnt == c_wait_limit);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wait_cnt   <= 8'd0;
      r_wait_abort <= 1'b0;
    end else begin
      if (w_next_state == c_st_tw) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= 8'd0;
      end
      if (w_timeout) begin
        r_wait_abort <= 1'b1;
      end
    end
  end

  assign mem.wait_abort = r_wait_abort;
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Bus request beats a simultaneous cycle request at every decision point.
  always_comb begin
    w_after_final = c_st_idle;
    if (!mem.n_busreq) begin
      w_after_final = c_st_busack;
    end else if (mem.req_valid) begin
      w_after_final = c_st_t1;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      c_st_idle:   w_next_state = w_after_final;
      c_st_t1:     w_next_state = c_st_t2;
      c_st_t2,
      c_st_tw: begin
        if (w_timeout) begin
          w_next_state = w_is_fetch ? c_st_t4 : c_st_t3;
        end else if (!mem.n_wait) begin
          w_next_state = c_st_tw;
        end else begin
          w_next_state = c_st_t3;
        end
      end
      c_st_t3:     w_next_state = w_is_fetch ? c_st_t4 : w_after_final;
      c_st_t4:     w_next_state = w_after_final;
      c_st_busack: w_next_state = mem.n_busreq ? c_st_idle : c_st_busack;
      default:     w_next_state = c_st_idle;
    endcase
  end

  // Request capture and refresh counter
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_type <= 2'b00;
      r_addr <= '0;
      r_dout <= 8'd0;
      r_rfsh <= 8'd0;
    end else begin
      if (w_accept) begin
        r_type <= mem.req_type;
        r_addr <= mem.req_addr;
        r_dout <= mem.req_dout;
      end
      // Only the low seven bits count; bit 7 is software-owned.
      if (r_state == c_st_t4) begin
        r_rfsh <= {r_rfsh[7], r_rfsh[6:0] + 7'd1};
      end
    end
  end

  assign mem.req_ready = w_req_ready;
  assign mem.bus_dout  = r_dout;

  // Output decode
  always_comb begin
    mem.n_m1       = 1'b1;
    mem.n_mreq     = 1'b1;
    mem.n_rd       = 1'b1;
    mem.n_wr       = 1'b1;
    mem.n_rfsh     = 1'b1;
    mem.n_busack   = 1'b1;
    mem.bus_oe     = 1'b1;
    mem.cycle_done = 1'b0;
    mem.din_we     = 1'b0;
    mem.bus_addr   = r_addr;
    unique case (r_state)
      c_st_t1: begin
        mem.n_mreq = 1'b0;
        mem.n_rd   = w_is_write;
        mem.n_m1   = !w_is_fetch;
      end
      c_st_t2,
      c_st_tw: begin
        mem.n_mreq = 1'b0;
        mem.n_rd   = w_is_write;
        mem.n_wr   = !w_is_write;
        mem.n_m1   = !w_is_fetch;
        mem.din_we = !w_is_write && mem.n_wait;
      end
      c_st_t3: begin
        if (w_is_fetch) begin
          mem.n_mreq   = 1'b0;
          mem.n_rfsh   = 1'b0;
          mem.bus_addr = w_rfsh_addr;
        end else begin
          mem.cycle_done = 1'b1;
        end
      end
      c_st_t4: begin
        mem.n_rfsh     = 1'b0;
        mem.bus_addr   = w_rfsh_addr;
        mem.cycle_done = 1'b1;
      end
      c_st_busack: begin
        mem.n_busack = 1'b0;
        mem.bus_oe   = 1'b0;
      end
      default: begin
        mem.bus_addr = r_addr;
      end
    endcase
  end

endmodule
`default_nettype wire
